ad9226_axis_packer: RTL and testbench
=====================================

# ad9226_axis_packer

Downstream stage of the AD9226 4-channel sample-hold block. Captures the four held channel words on each end-of-conversion (`eoc`) rising edge and serialises them as four AXI4-Stream beats, channel 0 first. Groups sample sets into packets with `m_axis_tlast` and flags sets dropped under back-pressure. Sits between the ADC capture FSM and the DMA/stream interconnect in the `axis_ad9226` IP.

## Interface
- `ADC_DATA_WIDTH`, 12: width of each channel sample.
- `AXIS_DATA_WIDTH`, 16: `m_axis_tdata` width; must be ≥ `ADC_DATA_WIDTH`.
- `FRAME_LEN`, 256: sample sets per packet; must be ≥1. Frame counter width is clog2(`FRAME_LEN`), minimum 1.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when high, `eoc` rising edges are accepted.
- `eoc`, in, 1: end-of-conversion level from the sample-hold stage.
- `data_in0`..`data_in3`, in, `ADC_DATA_WIDTH` each: held channel samples; stable while `eoc` is high.
- `m_axis_tvalid`, out, 1: AXIS valid.
- `m_axis_tready`, in, 1: AXIS ready.
- `m_axis_tdata`, out, `AXIS_DATA_WIDTH`: extended sample.
- `m_axis_tuser`, out, 2: channel index 0..3 of the current beat.
- `m_axis_tlast`, out, 1: high on the channel-3 beat of the last set in a frame.
- `overrun`, out, 1: sticky flag, set when a sample set is dropped.
- `clr_overrun`, in, 1: synchronous clear for `overrun`.

## Operation
- Edge detect: register `eoc_q`; `rise = eoc & ~eoc_q`. `eoc_q` resets to 1, so an `eoc` already high at reset release is not a capture.
- FSM states:
  - IDLE → SEND on `rise & enable`. On that edge, `data_in0..3` are latched into a 4-entry buffer and beat index `idx` is set to 0.
  - SEND: `tvalid` is 1. The output shows `buf[idx]`, with `tuser = idx`.
  - On a handshake (`tvalid & tready`), `idx` increments.
  - On the handshake with `idx == 3`: the FSM returns to IDLE, unless a `rise & enable` occurs in that same cycle. In that case the new set is latched, `idx` is set to 0, and the FSM stays in SEND with no bubble.
- Overrun: if `rise & enable` occurs in SEND and the cycle is not a final handshake, the new set is dropped. `overrun` is set the next cycle, the buffer is untouched and the frame counter does not advance.
  - `clr_overrun` clears `overrun`.
  - If set and clear coincide, set wins.
- Frame counter: `fcnt` increments on the final handshake of each set and wraps to 0 at `FRAME_LEN-1`.
  - `tlast = (idx == 3) & (fcnt == FRAME_LEN-1)`.
  - With `FRAME_LEN = 1`, every channel-3 beat has `tlast` set.
- `enable` low:
  - No new captures are taken.
  - A set already in SEND completes normally.
  - `fcnt` holds its value; it is not reset.
- AXIS rules:
  - Once `tvalid` is high, `tdata`, `tuser` and `tlast` are held until the handshake.
  - `tvalid` never drops without a handshake, except on reset.
- Width rule: the sample occupies `tdata[ADC_DATA_WIDTH-1:0]`. The upper bits are set per the Configuration section.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tuser`, `m_axis_tlast`, `overrun`: 0.
  - `fcnt`, `idx`: 0; FSM in IDLE; `eoc_q`: 1.
- Latency: clock edge N samples `eoc=1` with `eoc_q=0` → `tvalid=1` with channel-0 data after edge N.
- Throughput: with `tready` held high, 4 beats take 4 cycles, then IDLE. Minimum spacing between `eoc` rises is 4 cycles; a rise on the 4th beat is accepted back-to-back.
- Reset mid-packet: the partial set is discarded, `tvalid` drops at once and `fcnt` restarts at 0.
- Outputs are registered; there is no combinational path from `tready` to `tvalid`.

## Configuration
- `AD9226_PACK_SIGNED_EN` defined:
  - Each sample is treated as offset binary and converted to two's complement by inverting its MSB.
  - The result is sign-extended to `AXIS_DATA_WIDTH`.
  - Example: 12'h000 → 16'hF800, 12'h800 → 16'h0000, 12'hFFF → 16'h07FF.
- Not defined: the sample is zero-extended unchanged. Example: 12'hFFF → 16'h0FFF.

## Test plan
- Reset, then `eoc` pulse with `data_in0..3 = 12'h001, 12'h002, 12'h003, 12'h004` and `tready=1` → 4 consecutive beats with `tdata = 16'h0001..16'h0004`, `tuser = 0..3`, then `tvalid` returns to 0.
- `FRAME_LEN=4`, 8 sets with `tready=1` → `tlast` only on beats 16 and 32; `fcnt` wraps to 0.
- `tready` held low for 20 cycles after the first beat, and a second `eoc` rise at cycle 10 → `overrun=1`; buffer beats 0..3 delivered unchanged once `tready=1`; `clr_overrun` → `overrun=0`.
- Second `eoc` rise in the same cycle as the channel-3 handshake → next channel-0 beat on the following cycle, no idle cycle, `overrun` stays 0.
- `rst_n` low during the beat with `tuser=2`, `eoc` held high through release → `tvalid=0` immediately; no capture until the next `eoc` rise.
- Build with `AD9226_PACK_SIGNED_EN`, inputs 12'h000, 12'h800, 12'hFFF, 12'h7FF → `tdata` = 16'hF800, 16'h0000, 16'h07FF, 16'hFFFF.

Source files
------------

// File: rtl/ad9226_axis_packer.sv
// Serialises the four AD9226 channel words captured on each eoc rise into AXI4-Stream beats.
// Optional macro AD9226_PACK_SIGNED_EN: convert offset-binary samples to sign-extended two's complement.
module ad9226_axis_packer #(
  parameter int unsigned ADC_DATA_WIDTH  = 12,
  parameter int unsigned AXIS_DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN       = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       eoc,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in0,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in1,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in2,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in3,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]                 m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                                state_q, state_d;
  logic [1:0]                            idx_q, idx_d;
  logic [FCNT_W-1:0]                     fcnt_q, fcnt_d;
  logic [3:0][ADC_DATA_WIDTH-1:0]        sample_q, sample_d;
  logic                                  eoc_q;
  logic                                  overrun_d;
  logic                                  tvalid_d, tlast_d;
  logic [AXIS_DATA_WIDTH-1:0]            tdata_d;
  logic [1:0]                            tuser_d;
  logic                                  take, hs, last_hs;

  // Map one raw sample onto the stream word width.
  function automatic logic [AXIS_DATA_WIDTH-1:0] extend(input logic [ADC_DATA_WIDTH-1:0] s);
`ifdef AD9226_PACK_SIGNED_EN
    logic [ADC_DATA_WIDTH-1:0] t;
    t = s;
    t[ADC_DATA_WIDTH-1] = ~s[ADC_DATA_WIDTH-1];
    return AXIS_DATA_WIDTH'($signed(t));
`else
    return AXIS_DATA_WIDTH'(s);
`endif
  endfunction

  // Next-state, capture, frame count and registered-output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fcnt_d    = fcnt_q;
    sample_d  = sample_q;
    overrun_d = overrun;

    take    = eoc & ~eoc_q & enable;
    hs      = m_axis_tvalid & m_axis_tready;
    last_hs = hs & (idx_q == 2'd3);

    if (clr_overrun) overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d  = ST_SEND;
          idx_d    = 2'd0;
          sample_d = {data_in3, data_in2, data_in1, data_in0};
        end
      end
      ST_SEND: begin
        if (hs) idx_d = idx_q + 2'd1;
        if (last_hs) begin
          state_d = ST_IDLE;
          fcnt_d  = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_W'(1);
        end
        // A new set is only accepted when it lands on the final handshake.
        if (take) begin
          if (last_hs) begin
            state_d  = ST_SEND;
            idx_d    = 2'd0;
            sample_d = {data_in3, data_in2, data_in1, data_in0};
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tvalid_d = (state_d == ST_SEND);
    tdata_d  = extend(sample_d[idx_d]);
    tuser_d  = idx_d;
    tlast_d  = (idx_d == 2'd3) && (fcnt_d == FCNT_LAST);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      fcnt_q        <= '0;
      sample_q      <= '0;
      eoc_q         <= 1'b1;
      overrun       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 2'd0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      sample_q      <= sample_d;
      eoc_q         <= eoc;
      overrun       <= overrun_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tuser  <= tuser_d;
      m_axis_tlast  <= tlast_d;
    end
  end

endmodule

// File: tb/tb_ad9226_axis_packer.sv
// Bench for ad9226_axis_packer: queue-based reference model plus directed vectors with literal expectations.
module tb_ad9226_axis_packer;

  localparam int unsigned FL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        eoc = 1'b0;
  logic [11:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic        tvalid, tready = 1'b0, tlast, ovr, clr = 1'b0;
  logic [15:0] tdata;
  logic [1:0]  tuser;

  ad9226_axis_packer #(
    .ADC_DATA_WIDTH(12), .AXIS_DATA_WIDTH(16), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .eoc(eoc),
    .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .overrun(ovr), .clr_overrun(clr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

`ifdef AD9226_PACK_SIGNED_EN
  localparam logic [15:0] T1[4] = '{16'hF801, 16'hF802, 16'hF803, 16'hF804};
  localparam logic [15:0] T3[4] = '{16'hF911, 16'hFA22, 16'hFB33, 16'hFC44};
  localparam logic [15:0] T6[4] = '{16'hF800, 16'h0000, 16'h07FF, 16'hFFFF};
  function automatic logic [15:0] ext(input logic [11:0] s);
    return 16'(int'(s) - 2048);
  endfunction
`else
  localparam logic [15:0] T1[4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
  localparam logic [15:0] T3[4] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
  localparam logic [15:0] T6[4] = '{16'h0000, 16'h0800, 16'h0FFF, 16'h07FF};
  function automatic logic [15:0] ext(input logic [11:0] s);
    return 16'(s);
  endfunction
`endif

  // Reference model: a set is a group of four queued beats; a rise is accepted only if the queue drains this cycle.
  typedef struct packed {logic [15:0] data; logic [1:0] user; logic last;} beat_t;
  beat_t q[$];
  int    sets_taken;
  bit    prev_eoc, m_ovr, rise, drop, armed = 1'b0;
  logic [11:0] ins[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      sets_taken = 0;
      prev_eoc   = 1'b1;
      m_ovr      = 1'b0;
    end else begin
      rise = eoc && !prev_eoc;
      prev_eoc = eoc;
      drop = 1'b0;
      if (q.size() > 0 && tready) void'(q.pop_front());
      if (rise && enable) begin
        if (q.size() == 0) begin
          ins = '{d0, d1, d2, d3};
          for (int c = 0; c < 4; c++)
            q.push_back('{data: ext(ins[c]), user: 2'(c),
                          last: (c == 3) && ((sets_taken % FL) == FL - 1)});
          sets_taken++;
        end else drop = 1'b1;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    if (armed) begin
      check("m_tvalid", 32'(tvalid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("m_tdata", 32'(tdata), 32'(q[0].data));
        check("m_tuser", 32'(tuser), 32'(q[0].user));
        check("m_tlast", 32'(tlast), 32'(q[0].last));
      end
      check("m_overrun", 32'(ovr), 32'(m_ovr));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int tl_count, tl_first, tl_second;

  initial begin
    #1 rst_n = 1'b0;
    armed = 1'b1;
    step(3);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_overrun", 32'(ovr), 0);
    rst_n = 1'b1;
    step(2);

    // Single set, tready high.
    {d0, d1, d2, d3} = {12'h001, 12'h002, 12'h003, 12'h004};
    enable = 1'b1; tready = 1'b1; eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t1_tvalid", 32'(tvalid), 1);
      check("t1_tdata", 32'(tdata), 32'(T1[i]));
      check("t1_tuser", 32'(tuser), 32'(i));
      step(1);
    end
    check("t1_idle", 32'(tvalid), 0);

    // Eight back-to-back sets: tlast only on beats 16 and 32.
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    tl_count = 0; tl_first = 0; tl_second = 0;
    for (int s = 0; s < 8; s++) begin
      {d0, d1, d2, d3} = {12'(s), 12'(s + 16), 12'(s + 32), 12'(s + 48)};
      eoc = 1'b1;
      for (int b = 0; b < 4; b++) begin
        step(1);
        eoc = 1'b0;
        if (tvalid && tlast) begin
          tl_count++;
          if (tl_count == 1) tl_first = s * 4 + b + 1;
          if (tl_count == 2) tl_second = s * 4 + b + 1;
        end
      end
    end
    step(1);
    check("t2_tlast_cnt", 32'(tl_count), 2);
    check("t2_tlast_pos1", 32'(tl_first), 16);
    check("t2_tlast_pos2", 32'(tl_second), 32);
    check("t2_idle", 32'(tvalid), 0);

    // Back-pressure with a second rise mid-wait.
    tready = 1'b0;
    {d0, d1, d2, d3} = {12'h111, 12'h222, 12'h333, 12'h444};
    eoc = 1'b1; step(1); eoc = 1'b0;
    check("t3_ovr_pre", 32'(ovr), 0);
    step(9);
    {d0, d1, d2, d3} = {12'h005, 12'h006, 12'h007, 12'h008};
    eoc = 1'b1; step(1); eoc = 1'b0;
    check("t3_ovr_set", 32'(ovr), 1);
    step(9);
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_tdata", 32'(tdata), 32'(T3[i]));
      check("t3_tuser", 32'(tuser), 32'(i));
      step(1);
    end
    check("t3_idle", 32'(tvalid), 0);
    check("t3_ovr_sticky", 32'(ovr), 1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("t3_ovr_clr", 32'(ovr), 0);

    // Rise coincident with the channel-3 handshake: no bubble, no overrun.
    {d0, d1, d2, d3} = {12'h009, 12'h00A, 12'h00B, 12'h00C};
    eoc = 1'b1; step(1); eoc = 1'b0;
    step(3);
    check("t4_ch3", 32'(tuser), 3);
    {d0, d1, d2, d3} = {12'h00D, 12'h00E, 12'h00F, 12'h010};
    eoc = 1'b1; step(1); eoc = 1'b0;
    check("t4_tvalid", 32'(tvalid), 1);
    check("t4_tuser", 32'(tuser), 0);
    check("t4_ovr", 32'(ovr), 0);
    step(4);
    check("t4_idle", 32'(tvalid), 0);

    // Reset during the tuser=2 beat with eoc held high through release.
    eoc = 1'b1; step(1); eoc = 1'b0;
    step(2);
    check("t5_tuser2", 32'(tuser), 2);
    eoc = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_drop", 32'(tvalid), 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("t5_nocap", 32'(tvalid), 0);
    eoc = 1'b0; step(1);

    // Extension of boundary sample values.
    {d0, d1, d2, d3} = {12'h000, 12'h800, 12'hFFF, 12'h7FF};
    eoc = 1'b1; step(1); eoc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_tdata", 32'(tdata), 32'(T6[i]));
      step(1);
    end

    // Enable low: no capture; a set in flight still completes.
    enable = 1'b0;
    eoc = 1'b1; step(1); eoc = 1'b0; step(1);
    check("t7_nocap", 32'(tvalid), 0);
    enable = 1'b1;
    eoc = 1'b1; step(1); eoc = 1'b0;
    enable = 1'b0;
    step(3);
    check("t7_ch3", 32'(tvalid && tuser == 2'd3), 1);
    step(1);
    check("t7_done", 32'(tvalid), 0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
